uart_rx_cmd_parser: RTL and testbench

- Sits directly downstream of the 8-bit UART receiver and consumes its byte output.
- Synchronises the receiver's done strobe into the system clock domain, then assembles ASCII command frames of the form '#' CMD HH CR.
- Emits one decoded command (code + 8-bit argument) per valid frame, and flags malformed, errored or timed-out frames.
- Control logic (LED/transceiver steering) consumes its output.

---
 rtl/uart_cmd_pkg.sv | 36 +++
 rtl/uart_done_sync.sv | 40 ++++
 rtl/uart_rx_cmd_parser.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_cmd_parser.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types, constants and helpers for the UART command parser
//
// Purpose : FSM state encoding, frame delimiter characters and an ASCII hex
//           digit decoder shared by the parser and its bench.
// Macro   : UART_CMD_CKSUM_EN adds the checksum states CK_HI / CK_LO.
package uart_cmd_pkg;

   localparam logic [7:0] ASCII_HASH = 8'h23;
   localparam logic [7:0] ASCII_CR   = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ARG_HI,
      ST_ARG_LO,
`ifdef UART_CMD_CKSUM_EN
      ST_CK_HI,
      ST_CK_LO,
`endif
      ST_TERM
   } state_e;

   // Returns {valid, nibble}; nibble is zero when the character is not hex.
   function automatic logic [4:0] hex2nib(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39) begin
         r = {1'b1, c[3:0]};
      end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 maps them onto 10..15.
         r = {1'b1, c[3:0] + 4'd9};
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_done_sync.sv
// rtl/uart_done_sync.sv - two-flop synchroniser with registered rising-edge pulse
//
// Purpose : brings an asynchronous done level into clk_i and turns each rise
//           into a single-cycle pulse, three clocks after the rise.
// Ports   : clk_i   - destination clock
//           rst_i   - asynchronous active-high reset
//           async_i - asynchronous level (e.g. rxDone / txDone)
//           rise_o  - combinational edge detect, one cycle ahead of pulse_o
//           pulse_o - registered one-cycle pulse per rising edge of async_i
module uart_done_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic pulse_q;

   assign rise_o  = sync_q & ~prev_q;
   assign pulse_o = pulse_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         meta_q  <= async_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         pulse_q <= rise_o;
      end
   end

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// rtl/uart_rx_cmd_parser.sv - ASCII command frame parser behind the UART receiver
//
// Purpose : assembles frames '#' CMD HH CR (or '#' CMD HH KK CR with
//           UART_CMD_CKSUM_EN defined, KK = CMD ^ ARG) from received bytes and
//           emits one decoded command per good frame.
// Ports   : clk, rst              - system clock, async active-high reset
//           rx_data, rx_done,
//           rx_err                - receiver byte, async done level, framing error
//           cmd_valid             - one-cycle pulse, cmd_code/cmd_arg are new
//           cmd_code, cmd_arg     - command character and decoded argument
//           frame_err             - one-cycle pulse per rejected frame
//           err_count             - saturating rejected frame count
//           busy                  - frame in progress
module uart_rx_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned CLOCK_RATE     = 66000000,
   parameter int unsigned TIMEOUT_CYCLES = 6600000,
   parameter int unsigned ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_done,
   input  logic                 rx_err,
   output logic                 cmd_valid,
   output logic [7:0]           cmd_code,
   output logic [7:0]           cmd_arg,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 busy
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   // The clock rate only documents where TIMEOUT_CYCLES came from; a zero rate
   // would mean the timeout was never derived, so nothing extra is built.
   if (CLOCK_RATE == 0) begin : g_no_clock_rate
   end

   logic            byte_rise;
   logic            byte_stb;
   logic [7:0]      hold_data_q;
   logic            hold_err_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout;
   logic [4:0]      nib;

   state_e          state_q, state_d;
   logic [7:0]      code_q, code_d;
   logic [7:0]      arg_q, arg_d;
   logic            valid_d, err_d;
   logic            cmd_valid_q, frame_err_q;
   logic [7:0]      cmd_code_q, cmd_arg_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
`ifdef UART_CMD_CKSUM_EN
   logic [7:0]      ck_q, ck_d;
`endif

   uart_done_sync u_done_sync (
      .clk_i   (clk),
      .rst_i   (rst),
      .async_i (rx_done),
      .rise_o  (byte_rise),
      .pulse_o (byte_stb)
   );

   // Loaded on the edge that raises byte_stb, so the holding register is
   // already valid during the strobe cycle and costs no extra latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data_q <= 8'd0;
         hold_err_q  <= 1'b0;
      end else if (byte_rise) begin
         hold_data_q <= rx_data;
         hold_err_q  <= rx_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (byte_stb || state_q == ST_IDLE) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   assign timeout = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign nib     = hex2nib(hold_data_q);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      arg_d   = arg_q;
`ifdef UART_CMD_CKSUM_EN
      ck_d    = ck_q;
`endif
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (byte_stb) begin
         if (state_q != ST_IDLE && hold_err_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else if (state_q != ST_IDLE && hold_data_q == ASCII_HASH) begin
            // A fresh '#' mid-frame starts a new frame right away.
            err_d   = 1'b1;
            state_d = ST_CMD;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (!hold_err_q && hold_data_q == ASCII_HASH) state_d = ST_CMD;
               end
               ST_CMD: begin
                  code_d  = hold_data_q;
                  state_d = ST_ARG_HI;
               end
               ST_ARG_HI, ST_ARG_LO: begin
                  if (nib[4]) begin
                     arg_d = {arg_q[3:0], nib[3:0]};
`ifdef UART_CMD_CKSUM_EN
                     state_d = (state_q == ST_ARG_HI) ? ST_ARG_LO : ST_CK_HI;
`else
                     state_d = (state_q == ST_ARG_HI) ? ST_ARG_LO : ST_TERM;
`endif
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
`ifdef UART_CMD_CKSUM_EN
               ST_CK_HI: begin
                  if (nib[4]) begin
                     ck_d    = {ck_q[3:0], nib[3:0]};
                     state_d = ST_CK_LO;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               ST_CK_LO: begin
                  if (nib[4] && ({ck_q[3:0], nib[3:0]} == (code_q ^ arg_q))) begin
                     ck_d    = {ck_q[3:0], nib[3:0]};
                     state_d = ST_TERM;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
`endif
               ST_TERM: begin
                  if (hold_data_q == ASCII_CR) valid_d = 1'b1;
                  else                         err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end else if (timeout) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         code_q      <= 8'd0;
         arg_q       <= 8'd0;
`ifdef UART_CMD_CKSUM_EN
         ck_q        <= 8'd0;
`endif
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_code_q  <= 8'd0;
         cmd_arg_q   <= 8'd0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         arg_q       <= arg_d;
`ifdef UART_CMD_CKSUM_EN
         ck_q        <= ck_d;
`endif
         cmd_valid_q <= valid_d;
         frame_err_q <= err_d;
         if (valid_d) begin
            cmd_code_q <= code_q;
            cmd_arg_q  <= arg_q;
         end
         if (err_d && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_arg   = cmd_arg_q;
   assign frame_err = frame_err_q;
   assign err_count = err_cnt_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// tb/tb_uart_rx_cmd_parser.sv - scoreboard bench for uart_rx_cmd_parser
module tb_uart_rx_cmd_parser;

   localparam int unsigned TO        = 200;
   localparam int unsigned ERR_CNT_W = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [7:0]           rx_data = 8'd0;
   logic                 rx_done = 1'b0;
   logic                 rx_err = 1'b0;
   logic                 cmd_valid;
   logic [7:0]           cmd_code;
   logic [7:0]           cmd_arg;
   logic                 frame_err;
   logic [ERR_CNT_W-1:0] err_count;
   logic                 busy;

   uart_rx_cmd_parser #(
      .CLOCK_RATE     (66000000),
      .TIMEOUT_CYCLES (TO),
      .ERR_CNT_W      (ERR_CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_err    (rx_err),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_arg   (cmd_arg),
      .frame_err (frame_err),
      .err_count (err_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   logic [15:0] exp_q[$];
   logic [15:0] obs_q[$];
   int          obs_cyc_q[$];
   int          rise_cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          err_seen = 0;
   int          both_seen = 0;
   int          exp_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid) begin
            obs_q.push_back({cmd_code, cmd_arg});
            obs_cyc_q.push_back(cyc);
         end
         if (frame_err) err_seen = err_seen + 1;
         if (cmd_valid && frame_err) both_seen = both_seen + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
      if (n < 4'd10) return 8'h30 + {4'd0, n};
      return (lower ? 8'h61 : 8'h41) + {4'd0, n} - 8'd10;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic e);
      @(negedge clk);
      rx_data  = b;
      rx_err   = e;
      rx_done  = 1'b1;
      rise_cyc = cyc;
      repeat (5) @(negedge clk);
      rx_done = 1'b0;
      rx_err  = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
   endtask

   // Sends a well-formed frame and records the command it must produce.
   task automatic send_cmd(input logic [7:0] code, input logic [7:0] arg,
                           input bit lower, input bit with_hash);
      logic [7:0] ck;
      ck = code ^ arg;
      if (with_hash) send_byte(8'h23, 1'b0);
      send_byte(code, 1'b0);
      send_byte(hexc(arg[7:4], lower), 1'b0);
      send_byte(hexc(arg[3:0], lower), 1'b0);
`ifdef UART_CMD_CKSUM_EN
      send_byte(hexc(ck[7:4], 1'b0), 1'b0);
      send_byte(hexc(ck[3:0], 1'b0), 1'b0);
`endif
      exp_q.push_back({code, arg});
      send_byte(8'h0D, 1'b0);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({cmd_valid, frame_err, busy, cmd_code, cmd_arg, err_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_during: outputs %h, required 0",
                  {cmd_valid, frame_err, busy, cmd_code, cmd_arg, err_count});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({cmd_valid, frame_err, busy, cmd_code, cmd_arg, err_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_after: outputs %h, required 0",
                  {cmd_valid, frame_err, busy, cmd_code, cmd_arg, err_count});
      end
   endtask

   task automatic test_reset_midframe;
      send_str("#L");
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_busy: busy %b, required 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, cmd_valid, frame_err, err_count} !== '0) begin
         n_fail++;
         $display("FAIL midframe_reset: busy/valid/err/cnt %h, required 0",
                  {busy, cmd_valid, frame_err, err_count});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (err_seen !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_after: err pulses %0d busy %b, required 0 and 0", err_seen, busy);
      end
   endtask

   task automatic test_single;
      logic [15:0] o;
      int          oc;
      send_cmd(8'h4C, 8'h5A, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL single_cmd: no cmd_valid, required %h", exp_q[0]);
         exp_q.delete();
      end else begin
         o  = obs_q.pop_front();
         oc = obs_cyc_q.pop_front();
         if (o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_cmd: got %h, required %h", o, exp_q[0]);
         end
         void'(exp_q.pop_front());
         n_cmp++;
         if (oc - rise_cyc != 4) begin
            n_fail++;
            $display("FAIL single_latency: got %0d clk, required 4", oc - rise_cyc);
         end
      end
      n_cmp++;
      if (err_count !== ERR_CNT_W'(exp_err) || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL single_err: err_count %0d extra cmds %0d, required %0d and 0",
                  err_count, obs_q.size(), exp_err);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] e;
      logic [15:0] o;
      send_cmd(8'h4C, 8'hFF, 1'b1, 1'b1);
      send_cmd(8'h42, 8'h0F, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_cmd: no cmd_valid, required %h", e);
         end else begin
            o = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            if (o !== e) begin
               n_fail++;
               $display("FAIL b2b_cmd: got %h, required %h", o, e);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || err_count !== ERR_CNT_W'(exp_err)) begin
         n_fail++;
         $display("FAIL b2b_extra: extra cmds %0d err_count %0d, required 0 and %0d",
                  obs_q.size(), err_count, exp_err);
      end
      n_cmp++;
      if (cmd_code !== 8'h42 || cmd_arg !== 8'h0F) begin
         n_fail++;
         $display("FAIL b2b_hold: code/arg %h/%h, required 42/0f", cmd_code, cmd_arg);
      end
   endtask

   task automatic test_bad_hex;
      int base;
      base = err_seen;
      send_str("#LZ1\r");
      exp_err++;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (err_seen - base != 1 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL bad_hex: err pulses %0d cmds %0d, required 1 and 0",
                  err_seen - base, obs_q.size());
      end
      n_cmp++;
      if (err_count !== ERR_CNT_W'(exp_err) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_hex_state: err_count %0d busy %b, required %0d and 0",
                  err_count, busy, exp_err);
      end
      n_cmp++;
      if (cmd_code !== 8'h42 || cmd_arg !== 8'h0F) begin
         n_fail++;
         $display("FAIL bad_hex_hold: code/arg %h/%h, required 42/0f", cmd_code, cmd_arg);
      end
   endtask

   task automatic test_resync;
      int          base;
      logic [15:0] o;
      base = err_seen;
      send_str("#L#");
      exp_err++;
      send_cmd(8'h4C, 8'h12, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL resync_cmd: no cmd_valid, required %h", exp_q[0]);
         exp_q.delete();
      end else begin
         o = obs_q.pop_front();
         void'(obs_cyc_q.pop_front());
         if (o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL resync_cmd: got %h, required %h", o, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      n_cmp++;
      if (err_seen - base != 1 || err_count !== ERR_CNT_W'(exp_err)) begin
         n_fail++;
         $display("FAIL resync_err: pulses %0d err_count %0d, required 1 and %0d",
                  err_seen - base, err_count, exp_err);
      end
   endtask

   task automatic test_timeout;
      int base;
      int waited;
      base = err_seen;
      send_str("#L5");
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_busy: busy %b, required 1", busy);
      end
      waited = 0;
      while (err_seen == base && waited < 3 * TO) begin
         @(negedge clk);
         waited++;
      end
      exp_err++;
      n_cmp++;
      if (err_seen == base) begin
         n_fail++;
         $display("FAIL timeout_fire: no frame_err within %0d clk, required one", 3 * TO);
      end
      repeat (2 * TO) @(negedge clk);
      n_cmp++;
      if (err_seen - base != 1 || busy !== 1'b0 || err_count !== ERR_CNT_W'(exp_err)) begin
         n_fail++;
         $display("FAIL timeout_once: pulses %0d busy %b err_count %0d, required 1, 0, %0d",
                  err_seen - base, busy, err_count, exp_err);
      end
   endtask

   task automatic test_rx_err;
      int          base;
      logic [15:0] o;
      base = err_seen;
      send_byte(8'h23, 1'b1);
      send_byte(8'h78, 1'b0);
      n_cmp++;
      if (busy !== 1'b0 || err_seen != base) begin
         n_fail++;
         $display("FAIL idle_ignore: busy %b pulses %0d, required 0 and 0", busy, err_seen - base);
      end
      send_str("#L");
      send_byte(8'h35, 1'b1);
      exp_err++;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (err_seen - base != 1 || busy !== 1'b0 || err_count !== ERR_CNT_W'(exp_err)) begin
         n_fail++;
         $display("FAIL rx_err_frame: pulses %0d busy %b err_count %0d, required 1, 0, %0d",
                  err_seen - base, busy, err_count, exp_err);
      end
      send_cmd(8'h52, 8'hA7, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL rx_err_recover: no cmd_valid, required %h", exp_q[0]);
         exp_q.delete();
      end else begin
         o = obs_q.pop_front();
         void'(obs_cyc_q.pop_front());
         if (o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rx_err_recover: got %h, required %h", o, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

`ifdef UART_CMD_CKSUM_EN
   task automatic test_cksum;
      int          base;
      logic [15:0] o;
      base = err_seen;
      exp_q.push_back(16'h4C5A);
      send_str("#L5A16\r");
      repeat (4) @(negedge clk);
      n_cmp++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL cksum_good: no cmd_valid, required %h", exp_q[0]);
         exp_q.delete();
      end else begin
         o = obs_q.pop_front();
         void'(obs_cyc_q.pop_front());
         if (o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL cksum_good: got %h, required %h", o, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      send_str("#L5A17\r");
      exp_err++;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (err_seen - base != 1 || obs_q.size() != 0 || err_count !== ERR_CNT_W'(exp_err)) begin
         n_fail++;
         $display("FAIL cksum_bad: pulses %0d cmds %0d err_count %0d, required 1, 0, %0d",
                  err_seen - base, obs_q.size(), err_count, exp_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_midframe();
      test_single();
      test_back_to_back();
      test_bad_hex();
      test_resync();
      test_timeout();
      test_rx_err();
`ifdef UART_CMD_CKSUM_EN
      test_cksum();
`endif
      n_cmp++;
      if (both_seen != 0) begin
         n_fail++;
         $display("FAIL exclusive: cmd_valid with frame_err in %0d cycles, required 0", both_seen);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
